// File: rtl/mul_seq_ctrl_if.sv
// Bundle between the EXE stage and the MUL/MLA sequencer.
// Carries the request, the shared-ALU operand/result path and the completion status.
interface mul_seq_ctrl_if #(
    parameter int N = 32
);
    logic         start;
    logic         acc_en;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] acc_in;
    logic         c_in;
    logic         v_in;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_cmd;
    logic         alu_grant;
    logic [N-1:0] alu_out;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [3:0]   status;

    // EXE stage side: issues requests and feeds back the ALU result
    modport master (
        output start, acc_en, op_a, op_b, acc_in, c_in, v_in, alu_out,
        input  alu_a, alu_b, alu_cmd, alu_grant, busy, done, result, status
    );

    modport slave (
        input  start, acc_en, op_a, op_b, acc_in, c_in, v_in, alu_out,
        output alu_a, alu_b, alu_cmd, alu_grant, busy, done, result, status
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add MUL/MLA sequencer issuing one ADD per cycle to the shared EXE ALU.
// Stops as soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl #(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input logic           clk,
    input logic           rst,
    mul_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    localparam logic [3:0]       CMD_ADD = 4'b0010;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

    state_t           state;
    state_t           stateNext;
    logic [N-1:0]     acc;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic [CNT_W-1:0] cnt;
    logic             calcStep;
    logic             doneReg;
    logic [N-1:0]     resultReg;
    logic [3:0]       statusReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        calcStep  = 1'b0;
        case (state)
            IDLE: if (bus.start) stateNext = CALC;
            CALC: begin
                if (mplier == '0 || cnt == CNT_MAX) begin
                    stateNext = FIN;
                end else begin
                    calcStep = 1'b1;
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            doneReg   <= 1'b0;
            resultReg <= '0;
            statusReg <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= bus.acc_en ? bus.acc_in : '0;
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (calcStep) begin
                        // ALU carry-out is not consumed; the sum wraps mod 2^N
                        if (mplier[0]) acc <= bus.alu_out;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    resultReg <= acc;
                    statusReg <= {acc[N-1], acc == '0, bus.c_in, bus.v_in};
                    doneReg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ALU operands come straight from registers, gated to zero when not granted
    assign bus.alu_grant = (state == CALC);
    assign bus.alu_cmd   = bus.alu_grant ? CMD_ADD : '0;
    assign bus.alu_a     = bus.alu_grant ? acc : '0;
    assign bus.alu_b     = bus.alu_grant ? mcand : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = doneReg;
    assign bus.result    = resultReg;
    assign bus.status    = statusReg;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed and random MUL/MLA operations against a 64-bit
// arithmetic product model, with a behavioural ADD/SUB ALU closing the loop.
module tb_mul_seq_ctrl;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [N-1:0] lastResult = '0;

    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.N(N)) bus ();

    mul_seq_ctrl #(.N(N), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Any command other than ADD returns a difference so a wrong opcode is visible
    assign bus.alu_out = (bus.alu_cmd == 4'b0010) ? bus.alu_a + bus.alu_b : bus.alu_a - bus.alu_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a posedge; drives start immediately and follows the op to done.
    task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b, input logic ae,
                         input logic [N-1:0] ai, input logic c, input logic v,
                         input logic poke, input string tag);
        logic [63:0]  full;
        logic [N-1:0] expRes;
        logic [3:0]   expSt;
        int unsigned  k;
        int unsigned  edges;
        int unsigned  calc;
        logic         seen;
        full   = 64'(a) * 64'(b) + 64'(ae ? ai : '0);
        expRes = full[N-1:0];
        expSt  = {expRes[N-1], expRes == '0, c, v};
        k = 0;
        for (int i = 0; i < N; i++) if (b[i]) k = i + 1;

        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.acc_en = ae;
        bus.acc_in = ai;
        bus.c_in   = c;
        bus.v_in   = v;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_hold"}, 64'(bus.result), 64'(lastResult));
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.acc_in = $urandom;
        bus.acc_en = 1'($urandom);

        edges = 1;
        calc  = 0;
        seen  = 1'b0;
        while (!seen && edges < N + 10) begin
            if (bus.alu_grant) begin
                calc++;
                check({tag, "_cmd"}, 64'(bus.alu_cmd), 64'h2);
            end
            if (poke && edges == 2) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            edges++;
            seen = bus.done;
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(edges), 64'(k + 3));
        check({tag, "_calc"}, 64'(calc), 64'(k + 1));
        check({tag, "_res"}, 64'(bus.result), 64'(expRes));
        check({tag, "_st"}, 64'(bus.status), 64'(expSt));
        lastResult = expRes;
    endtask

    task automatic idleCheck(input string tag);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_keep"}, 64'(bus.result), 64'(lastResult));
    endtask

    initial begin
        int unsigned doneCnt;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         b2b;
        bus.start  = 1'b0;
        bus.acc_en = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.acc_in = '0;
        bus.c_in   = 1'b0;
        bus.v_in   = 1'b0;

        #2;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_grant", 64'(bus.alu_grant), 64'd0);
        check("rst_cmd", 64'(bus.alu_cmd), 64'd0);
        check("rst_a", 64'(bus.alu_a), 64'd0);
        check("rst_b", 64'(bus.alu_b), 64'd0);
        check("rst_res", 64'(bus.result), 64'd0);
        check("rst_st", 64'(bus.status), 64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        runOp(32'd7, 32'd6, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "mul");
        idleCheck("mul");

        // Abort in the fifth CALC cycle: everything drops at once and no done follows
        bus.start = 1'b1;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_grant_pre", 64'(bus.alu_grant), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_grant", 64'(bus.alu_grant), 64'd0);
        check("abort_cmd", 64'(bus.alu_cmd), 64'd0);
        check("abort_res", 64'(bus.result), 64'd0);
        #2;
        rst = 1'b0;
        lastResult = '0;
        doneCnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) doneCnt++;
        end
        check("abort_nodone", 64'(doneCnt), 64'd0);

        runOp(32'd5, 32'd0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, "mla0");
        idleCheck("mla0");
        runOp(32'd5, 32'd0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, "mlaz");
        idleCheck("mlaz");
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "wrap");
        idleCheck("wrap");
        runOp(32'h8000_0000, 32'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "neg");
        idleCheck("neg");
        runOp(32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, "ovf");
        idleCheck("ovf");

        runOp(32'h1234, 32'hFF, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, "poke");
        runOp(32'h0BAD, 32'h13, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "b2b");
        idleCheck("b2b");

        for (int i = 0; i < 16; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rb  = rb >> $urandom_range(0, 31);
            b2b = 1'($urandom);
            runOp(ra, rb, 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom), "rnd");
            if (!b2b) idleCheck("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle shift-and-add sequencer that implements ARM MUL/MLA (low 32-bit product) by driving a shared, external N-bit ALU instance with ADD commands, one ALU operation per cycle.
- Sits in the EXE stage beside the ALU. The EXE stage stalls the pipeline while busy=1 and muxes the ALU inputs to this block while alu_grant=1.
- Iteration terminates early once the remaining multiplier bits are zero.

Parameters:
- N, 32, operand/result width (must match ALU N)
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > N)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- acc_en  input  1  1 = MLA (seed accumulator with acc_in), 0 = MUL (seed 0)
- op_a  input  N  multiplicand (Rm)
- op_b  input  N  multiplier (Rs)
- acc_in  input  N  accumulate operand (Rn)
- c_in  input  1  current CPSR C, passed through to status
- v_in  input  1  current CPSR V, passed through to status
- alu_a  output  N  ALU operand a (accumulator)
- alu_b  output  N  ALU operand b (shifted multiplicand)
- alu_cmd  output  4  ALU exeCmd
- alu_grant  output  1  1 while the block owns the ALU
- alu_out  input  N  ALU result
- busy  output  1  1 from the cycle after start acceptance until done
- done  output  1  one-cycle pulse; result and status valid
- result  output  N  product, held until next accepted start
- status  output  4  {n,z,c,v} for MULS/MLAS, held with result

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, alu_grant=0, alu_cmd=4'b0000, alu_a=0, alu_b=0, result=0, status=0, all internal regs=0.
- Reset mid-operation aborts with no done pulse. result returns to 0.
- States: IDLE, CALC, FIN.
- IDLE:
  - alu_grant=0, alu_cmd=4'b0000.
  - On start=1: acc<=acc_en?acc_in:0; mcand<=op_a; mplier<=op_b; cnt<=0; go to CALC.
  - start=0: stay in IDLE.
- CALC:
  - busy=1, alu_grant=1, alu_cmd=4'b0010 (ADD), alu_a=acc, alu_b=mcand.
  - If mplier==0 or cnt==N: go to FIN with no register update.
  - Else:
    - if mplier[0]=1, acc<=alu_out, taking the low N bits; ALU carry is ignored and the sum wraps mod 2^N.
    - mcand<=mcand<<1, with 0 shifted in and the MSB discarded.
    - mplier<=mplier>>1, logical.
    - cnt<=cnt+1.
- FIN:
  - busy=1, alu_grant=0.
  - result<=acc; status<={acc[N-1], acc==0, c_in, v_in}; done<=1 for exactly the next cycle; go to IDLE.
  - done is asserted in the first IDLE cycle.
- Latency: let k = (index of the highest set bit of op_b)+1, with k=0 if op_b=0. CALC lasts k+1 cycles. done rises k+3 edges after the start edge, so N+3 worst case.
- start is ignored while busy=1 or in the done cycle's FIN→IDLE transition. A start in the same cycle done=1 (state IDLE) is accepted; result/status keep their old values until the new FIN.
- Operands are sampled only at acceptance. Later changes to op_a/op_b/acc_in/acc_en have no effect on an operation in progress.
- Signedness is irrelevant: the low N bits are identical for signed and unsigned operands.
- alu_a/alu_b are driven from registers, so there is no combinational path from the inputs to the ALU operands.

Test Plan:
- Reset mid-CALC: start with op_a=3, op_b=0xFFFF_FFFF; assert rst in the 5th CALC cycle → busy=0, alu_grant=0, result=0 immediately; no done pulse follows.
- MUL basic: op_a=7, op_b=6, acc_en=0 → done 6 edges after start, result=42, status=4'b00{c_in,v_in}; alu_cmd=0010 during all 4 CALC cycles.
- MLA plus zero multiplier:
  - op_a=5, op_b=0, acc_en=1, acc_in=0x10 → CALC 1 cycle, done 3 edges after start, result=0x10.
  - Same with acc_in=0 → status z=1.
- Wrap and negative:
  - op_a=0xFFFF_FFFF, op_b=0xFFFF_FFFF → result=1 after N+3 edges, n=0, z=0.
  - op_a=0x8000_0000, op_b=1 → result=0x8000_0000, n=1.
- Overflow to zero: op_a=0x0001_0000, op_b=0x0001_0000 → result=0, z=1; ALU carry discarded; c/v equal c_in/v_in.
- Handshake:
  - start pulsed during busy → ignored; in-flight result unchanged.
  - start asserted in the cycle done=1 → accepted; busy=1 on the next cycle; back-to-back results correct.
